spi_mem_bank: RTL and testbench
===============================

Name: spi_mem_bank

Overview:
Parametrised single-port memory slave behind the SPI frame interface. It decodes command-tagged receive words into address set, write, and read operations, with auto-increment burst reads and writes. Read data returns over a valid/ready transmit handshake. It sits between the SPI slave deserialiser (rx side) and serialiser (tx side) and supersedes the fixed 8-bit, 256-deep combinational-read memory.

Parameters:
DATA_W, 8, memory word width
ADDR_W, 8, address width
MEM_DEPTH, 2**ADDR_W, number of words; must be <= 2**ADDR_W
PAY_W, max(ADDR_W,DATA_W), payload field width of a receive frame (derived, localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
cs_n  in  1  SPI chip select, active-low; high = deselected
rx_valid  in  1  din holds a complete frame
rx_ready  out  1  block can accept a frame this cycle
din  in  2+PAY_W  frame: [PAY_W+1:PAY_W]=cmd, [PAY_W-1:0]=payload
dout  out  DATA_W  read data, valid while tx_valid
tx_valid  out  1  read data available
tx_ready  in  1  serialiser consumes dout
err  out  1  sticky protocol error flag

Behaviour:
- Frame accepted when rx_valid & rx_ready & ~cs_n; frames while cs_n=1 are ignored.
- Commands:
  - 00 WADDR: wr_addr <= payload[ADDR_W-1:0]; wr_ok <= 1.
  - 01 WDATA: if wr_ok, mem[wr_addr] <= payload[DATA_W-1:0] and wr_addr <= wr_addr+1; else err <= 1 and no write.
  - 10 RADDR: rd_addr <= payload[ADDR_W-1:0]; rd_ok <= 1; starts a read of that address.
  - 11 RNEXT: if rd_ok, starts a read at rd_addr; else err <= 1.
  - Every read post-increments rd_addr after issue.
- Address increment wraps MEM_DEPTH-1 -> 0, not 2**ADDR_W-1.
- Payload bits above the used width are ignored.
- FSM states IDLE, RD (memory access cycle), TX (holding data).
  - IDLE: rx_ready=1. A read command -> RD.
  - RD: rx_ready=0; mem registered into dout -> TX.
  - TX: rx_ready=0, tx_valid=1, dout stable; tx_ready=1 -> IDLE (tx_valid low next cycle).
- Read latency: read frame accepted at edge N, tx_valid=1 after edge N+2.
- Writes complete in the accepting cycle; rx_ready stays 1 in IDLE, so back-to-back writes run at one per clock.
- Write-then-read of the same address returns the new data (write lands at edge N; read samples memory at edge N+1 or later).
- cs_n rising (deselect), sampled synchronously:
  - FSM -> IDLE; tx_valid -> 0 next cycle.
  - Any pending read is discarded.
  - wr_ok, rd_ok -> 0.
  - Addresses and err are kept.
- err clears only on reset.
- Reset values: rx_ready=0 while rst_n low then 1; tx_valid=0; dout=0; err=0; wr_addr=rd_addr=0; wr_ok=rd_ok=0; state IDLE.
- Memory contents are not reset.
- Reset asserted mid-read: outputs go to reset values immediately (asynchronous); the read is lost.
- tx_ready while tx_valid=0 is ignored.
- MEM_DEPTH < 2**ADDR_W, address >= MEM_DEPTH: write dropped and err set; read returns 0 and err set.

Decomposition:
- Package spi_mem_pkg: 2-bit command encodings CMD_WADDR/CMD_WDATA/CMD_RADDR/CMD_RNEXT, FSM state encoding, CMD_W=2 constant.
- Sub-module spi_mem_array: synchronous single-port RAM (DATA_W x MEM_DEPTH; we, addr, wdata, registered rdata). Isolates storage for later SRAM macro swap.
- Top holds FSM, address counters, flags and err.

Test Plan:
- Reset, then WADDR 0x10, WDATA 0xA5, RADDR 0x10, tx_ready held 1 -> tx_valid high exactly 2 cycles after the RADDR accept, dout=0xA5, rx_ready low for 3 cycles.
- Burst: WADDR 0xFE, WDATA 0x11/0x22/0x33 back-to-back; RADDR 0xFE, RNEXT, RNEXT -> dout sequence 0x11, 0x22, 0x33 (address 0xFF wraps to 0x00).
- Backpressure: read of a location holding 0x5C with tx_ready=0 for 5 cycles -> tx_valid and dout=0x5C stable; incoming rx_valid frames not accepted; tx_ready=1 -> IDLE next cycle.
- Protocol error: after reset, WDATA 0x77 -> err=1, no memory location written; RNEXT before any RADDR -> err=1, no tx_valid.
- Deselect: RADDR issued, cs_n raised during RD -> tx_valid never asserts; WDATA after reselect without WADDR -> err=1.
- Async reset pulse while tx_valid=1 -> tx_valid=0 and dout=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared command encodings and FSM state type for the SPI-attached memory bank.
package spi_mem_pkg;
  localparam int CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_WADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WDATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RNEXT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_TX   = 2'd2
  } state_t;
endpackage

// File: rtl/spi_mem_array.sv
// Synchronous single-port RAM with registered read data; kept separate so an SRAM macro can replace it.
module spi_mem_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/spi_mem_bank.sv
// Command-decoding memory slave between the SPI deserialiser and serialiser, with auto-increment bursts.
module spi_mem_bank
  import spi_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W,
  localparam int PAY_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [CMD_W+PAY_W-1:0] din,
  output logic [DATA_W-1:0]      dout,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   err
);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] LAST_V  = (ADDR_W+1)'(MEM_DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  // Wrap at the populated depth, not at the address-space limit.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} >= LAST_V) return '0;
    return a + ADDR_W'(1);
  endfunction

  state_t            state, state_nx;
  logic              rd_ph;
  logic [ADDR_W-1:0] wr_addr, rd_addr, rd_iss;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] ram_rdata;

  logic [CMD_W-1:0]  cmd;
  logic [PAY_W-1:0]  pay;
  logic [ADDR_W-1:0] pay_addr;
  logic [DATA_W-1:0] pay_data;
  logic              accept, rd_start, ram_we;

  assign cmd      = din[CMD_W+PAY_W-1:PAY_W];
  assign pay      = din[PAY_W-1:0];
  assign pay_addr = pay[ADDR_W-1:0];
  assign pay_data = pay[DATA_W-1:0];

  assign rx_ready = rst_n && (state == ST_IDLE);
  assign tx_valid = (state == ST_TX);
  assign accept   = rx_valid && rx_ready && !cs_n;
  assign rd_start = accept && ((cmd == CMD_RADDR) || (cmd == CMD_RNEXT && rd_ok));
  assign ram_we   = accept && (cmd == CMD_WDATA) && wr_ok && in_range(wr_addr);

  spi_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    ((state == ST_RD) && !rd_ph),
    .addr  ((state == ST_RD) ? rd_iss : wr_addr),
    .wdata (pay_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (rd_start) state_nx = ST_RD;
      ST_RD:   if (rd_ph) state_nx = ST_TX;
      ST_TX:   if (tx_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (cs_n) state_nx = ST_IDLE;
  end

  // RD spans two cycles: RAM access, then capture into dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rd_ph <= 1'b0;
    end else begin
      state <= state_nx;
      rd_ph <= (state == ST_RD) && !rd_ph && !cs_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      rd_addr <= '0;
      rd_iss  <= '0;
      wr_ok   <= 1'b0;
      rd_ok   <= 1'b0;
      err     <= 1'b0;
      dout    <= '0;
    end else begin
      if (state == ST_RD && rd_ph && !cs_n) dout <= in_range(rd_iss) ? ram_rdata : '0;
      if (cs_n) begin
        wr_ok <= 1'b0;
        rd_ok <= 1'b0;
      end else if (accept) begin
        case (cmd)
          CMD_WADDR: begin
            wr_addr <= pay_addr;
            wr_ok   <= 1'b1;
          end
          CMD_WDATA: begin
            if (!wr_ok) err <= 1'b1;
            else begin
              if (!in_range(wr_addr)) err <= 1'b1;
              wr_addr <= next_addr(wr_addr);
            end
          end
          CMD_RADDR: begin
            rd_ok   <= 1'b1;
            rd_iss  <= pay_addr;
            rd_addr <= next_addr(pay_addr);
            if (!in_range(pay_addr)) err <= 1'b1;
          end
          default: begin
            if (!rd_ok) err <= 1'b1;
            else begin
              rd_iss  <= rd_addr;
              rd_addr <= next_addr(rd_addr);
              if (!in_range(rd_addr)) err <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_bank.sv
// Bench for spi_mem_bank: vector table, directed corner sequences and a randomized run against a transaction model.
module tb_spi_mem_bank;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, rx_valid, rx_ready, tx_valid, tx_ready, err;
  logic [9:0] din;
  logic [7:0] dout;

  spi_mem_bank dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .din(din), .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference state
  logic [7:0] m_mem [DEPTH];
  int         m_wa, m_ra;
  bit         m_wok, m_rok, m_err;
  int         bp_fixed = -1;
  bit         bp_poke = 1'b0;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] pay;
    bit         rd;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wa = 0; m_ra = 0; m_wok = 0; m_rok = 0; m_err = 0;
  endtask

  task automatic model(input logic [1:0] c, input logic [7:0] p, output bit rd, output logic [7:0] d);
    rd = 0; d = '0;
    case (c)
      2'd0: begin m_wa = int'(p); m_wok = 1; end
      2'd1: if (m_wok) begin m_mem[m_wa] = p; m_wa = (m_wa + 1) % DEPTH; end else m_err = 1;
      2'd2: begin m_rok = 1; rd = 1; d = m_mem[p]; m_ra = (int'(p) + 1) % DEPTH; end
      default: if (m_rok) begin rd = 1; d = m_mem[m_ra]; m_ra = (m_ra + 1) % DEPTH; end else m_err = 1;
    endcase
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p, output bit ok);
    int n = 0;
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    ok = rx_ready;
    if (!ok) begin chk("send_rx_ready", {31'd0, rx_ready}, 32'd1); return; end
    rx_valid = 1'b1; din = {c, p};
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic op(input logic [1:0] c, input logic [7:0] p, output logic [7:0] got);
    bit rd, ok;
    logic [7:0] exp;
    int d;
    got = '0;
    tx_ready = 1'b1;
    model(c, p, rd, exp);
    send(c, p, ok);
    if (!ok) return;
    if (rd) begin
      chk("busy_c1", {31'd0, rx_ready}, 0); chk("txv_c1", {31'd0, tx_valid}, 0);
      @(negedge clk);
      chk("busy_c2", {31'd0, rx_ready}, 0); chk("txv_c2", {31'd0, tx_valid}, 0);
      @(negedge clk);
      chk("busy_c3", {31'd0, rx_ready}, 0); chk("txv_c3", {31'd0, tx_valid}, 1);
      got = dout;
      chk("dout", {24'd0, dout}, {24'd0, exp});
      d = (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 3));
      if (d > 0) begin
        tx_ready = 1'b0;
        if (bp_poke) begin rx_valid = 1'b1; din = {2'b00, 8'h99}; end
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          chk("bp_txv", {31'd0, tx_valid}, 1);
          chk("bp_dout", {24'd0, dout}, {24'd0, exp});
          chk("bp_busy", {31'd0, rx_ready}, 0);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
      end
      @(negedge clk);
      chk("txv_done", {31'd0, tx_valid}, 0); chk("idle_ready", {31'd0, rx_ready}, 1);
    end else begin
      chk("txv_none", {31'd0, tx_valid}, 0); chk("wr_ready", {31'd0, rx_ready}, 1);
    end
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic deselect();
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    m_wok = 0; m_rok = 0;
  endtask

  task automatic dump_all();
    logic [7:0] g;
    op(2'd2, 8'h00, g);
    for (int i = 1; i < DEPTH; i++) op(2'd3, 8'h00, g);
  endtask

  initial begin
    logic [7:0] g;
    bit rd, ok;
    logic [7:0] e;
    int n;

    vt[0] = '{2'd0, 8'h10, 0, 8'h00};
    vt[1] = '{2'd1, 8'hA5, 0, 8'h00};
    vt[2] = '{2'd2, 8'h10, 1, 8'hA5};
    vt[3] = '{2'd0, 8'hFE, 0, 8'h00};
    vt[4] = '{2'd1, 8'h11, 0, 8'h00};
    vt[5] = '{2'd1, 8'h22, 0, 8'h00};
    vt[6] = '{2'd1, 8'h33, 0, 8'h00};
    vt[7] = '{2'd2, 8'hFE, 1, 8'h11};
    vt[8] = '{2'd3, 8'h00, 1, 8'h22};
    vt[9] = '{2'd3, 8'h00, 1, 8'h33};

    rst_n = 1'b0; cs_n = 1'b0; rx_valid = 1'b0; din = '0; tx_ready = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_rx_ready", {31'd0, rx_ready}, 0);
      chk("rst_tx_valid", {31'd0, tx_valid}, 0);
      chk("rst_dout", {24'd0, dout}, 0);
      chk("rst_err", {31'd0, err}, 0);
    end
    rst_n = 1'b1;
    #1 chk("rst_release_ready", {31'd0, rx_ready}, 1);

    // Fill the whole array so the model knows every location
    op(2'd0, 8'h00, g);
    for (int i = 0; i < DEPTH; i++) op(2'd1, 8'($urandom), g);

    bp_fixed = 0;
    for (int i = 0; i < 10; i++) begin
      op(vt[i].cmd, vt[i].pay, g);
      if (vt[i].rd) chk("tbl_dout", {24'd0, g}, {24'd0, vt[i].exp});
    end

    op(2'd0, 8'h40, g);
    op(2'd1, 8'h5C, g);
    bp_fixed = 5; bp_poke = 1'b1;
    op(2'd2, 8'h40, g);
    chk("bp_result", {24'd0, g}, 32'h5C);
    bp_fixed = -1; bp_poke = 1'b0;
    op(2'd2, 8'h40, g);
    chk("bp_no_side_write", {24'd0, g}, 32'h5C);

    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 99));
      if (n < 6) deselect();
      else op(2'($urandom), 8'($urandom), g);
    end

    do_reset();
    op(2'd1, 8'h77, g);
    chk("perr_wdata", {31'd0, err}, 1);
    op(2'd3, 8'h00, g);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("perr_no_txv", {31'd0, tx_valid}, 0);
    end
    dump_all();

    do_reset();
    op(2'd0, 8'h20, g);
    model(2'd2, 8'h30, rd, e);
    send(2'd2, 8'h30, ok);
    cs_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("desel_no_txv", {31'd0, tx_valid}, 0);
    end
    cs_n = 1'b0; m_wok = 0; m_rok = 0;
    chk("desel_err_clear", {31'd0, err}, 0);
    op(2'd1, 8'h12, g);
    chk("desel_wdata_err", {31'd0, err}, 1);

    do_reset();
    tx_ready = 1'b0;
    model(2'd2, 8'h40, rd, e);
    send(2'd2, 8'h40, ok);
    n = 0;
    while (!tx_valid && n < 10) begin @(negedge clk); n++; end
    chk("ar_txv_before", {31'd0, tx_valid}, 1);
    chk("ar_dout_before", {24'd0, dout}, {24'd0, e});
    #2 rst_n = 1'b0;
    #1;
    chk("ar_txv", {31'd0, tx_valid}, 0);
    chk("ar_dout", {24'd0, dout}, 0);
    chk("ar_rx_ready", {31'd0, rx_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1; tx_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("ar_idle", {31'd0, tx_valid}, 0);
    op(2'd2, 8'h40, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
